// File: rtl/multiplicador_segmentado.sv
// Pipelined signed reconstructor Num = Coc*Den + Res, one shift-and-add stage per bit.
// Optional feature: define MULT_OVF_EN to compute Ovf; otherwise Ovf is tied low.
module multiplicador_segmentado #(
  parameter int unsigned tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic [tamanyo-1:0] Coc,
  input  logic [tamanyo-1:0] Den,
  input  logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic [tamanyo-1:0] Num,
  output logic               Ovf
);

  localparam int unsigned W  = tamanyo;
  localparam int unsigned W2 = 2 * tamanyo;
  localparam int unsigned WS = 2 * tamanyo + 1;

  logic [W:0]    r_v;
  logic [W-1:0]  r_a   [0:W-1];
  logic [W-1:0]  r_b   [0:W-1];
  logic [W-1:0]  r_res [0:W];
  logic          r_neg [0:W];
  logic [W2-1:0] r_acc [0:W];

  logic [W-1:0]  w_coc_abs;
  logic [W-1:0]  w_den_abs;
  logic [W2-1:0] w_prod;
  logic [W-1:0]  w_num;
  logic          w_ovf;

  // Most-negative input wraps to 2^(W-1), which is its true magnitude as unsigned.
  assign w_coc_abs = Coc[W-1] ? W'(~Coc + W'(1)) : Coc;
  assign w_den_abs = Den[W-1] ? W'(~Den + W'(1)) : Den;

  // Valid bits shift one stage per clock; only they need reset.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[W-1:0], Start};
    end
  end

  // Capture plus one conditional add of the shifted multiplier per stage.
  always_ff @(posedge CLK) begin
    if (Start) begin
      r_a[0]   <= w_coc_abs;
      r_b[0]   <= w_den_abs;
      r_neg[0] <= Coc[W-1] ^ Den[W-1];
      r_res[0] <= Res;
      r_acc[0] <= '0;
    end
    for (int unsigned k = 1; k <= W; k++) begin
      if (k < W) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      r_neg[k] <= r_neg[k-1];
      r_res[k] <= r_res[k-1];
      r_acc[k] <= r_acc[k-1] +
                  (r_a[k-1][k-1] ? (W2'(r_b[k-1]) << (k - 1)) : W2'(0));
    end
  end

  assign w_prod = r_neg[W] ? W2'(~r_acc[W] + W2'(1)) : r_acc[W];

`ifdef MULT_OVF_EN
  logic [WS-1:0] w_sum;

  assign w_sum = {w_prod[W2-1], w_prod} + {{(WS - W){r_res[W][W-1]}}, r_res[W]};
  assign w_num = w_sum[W-1:0];
  assign w_ovf = (w_sum != {{(WS - W){w_sum[W-1]}}, w_sum[W-1:0]});
`else
  logic w_unused_hi;

  // Low bits of the product are all the wrapped result needs.
  assign w_num       = w_prod[W-1:0] + r_res[W];
  assign w_ovf       = 1'b0;
  assign w_unused_hi = ^w_prod[W2-1:W];
`endif

  // Output stage: Num/Ovf hold their last value during bubbles.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      Done <= 1'b0;
      Num  <= '0;
      Ovf  <= 1'b0;
    end else begin
      Done <= r_v[W];
      if (r_v[W]) begin
        Num <= w_num;
        Ovf <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multiplicador_segmentado.sv
// Scoreboard bench for multiplicador_segmentado (tamanyo=8): random and directed ops vs arithmetic model.
module tb_multiplicador_segmentado;

  localparam int unsigned N   = 8;
  localparam int          LAT = N + 1;

`ifdef MULT_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RSTa;
  logic         Start;
  logic [N-1:0] Coc, Den, Res;
  logic         Done;
  logic [N-1:0] Num;
  logic         Ovf;

  typedef struct {
    int           due;
    logic [N-1:0] num;
    logic         ovf;
  } exp_t;

  exp_t         q[$];
  int           cyc    = 0;
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] last_num = '0;
  logic         last_ovf = 1'b0;

  multiplicador_segmentado #(.tamanyo(N)) dut (
    .CLK(CLK), .RSTa(RSTa), .Start(Start),
    .Coc(Coc), .Den(Den), .Res(Res),
    .Done(Done), .Num(Num), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  // Monitor: compare once per cycle, 1 time unit after the rising edge.
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (RSTa) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (!Done) begin
          errors++;
          $display("FAIL done_missing cyc=%0d got Done=0 want 1", cyc);
        end else begin
          if (Num !== e.num || Ovf !== e.ovf) begin
            errors++;
            $display("FAIL result cyc=%0d got Num=%02h Ovf=%b want Num=%02h Ovf=%b",
                     cyc, Num, Ovf, e.num, e.ovf);
          end
          last_num = e.num;
          last_ovf = e.ovf;
        end
      end else begin
        checks++;
        if (Done !== 1'b0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d got Done=%b want 0", cyc, Done);
        end else if (Num !== last_num || Ovf !== last_ovf) begin
          errors++;
          $display("FAIL hold cyc=%0d got Num=%02h Ovf=%b want Num=%02h Ovf=%b",
                   cyc, Num, Ovf, last_num, last_ovf);
        end
      end
    end
  end

  function automatic exp_t model(input logic [N-1:0] c, input logic [N-1:0] d,
                                 input logic [N-1:0] r, input int due);
    exp_t   e;
    longint p;
    p     = longint'($signed(c)) * longint'($signed(d)) + longint'($signed(r));
    e.due = due;
    e.num = N'(p);
    e.ovf = OVF_EN && (p > 127 || p < -128);
    return e;
  endfunction

  task automatic op(input logic [N-1:0] c, input logic [N-1:0] d, input logic [N-1:0] r);
    @(negedge CLK);
    Start = 1'b1;
    Coc = c; Den = d; Res = r;
    q.push_back(model(c, d, r, cyc + 1 + LAT));
  endtask

  task automatic op_exp(input logic [N-1:0] c, input logic [N-1:0] d, input logic [N-1:0] r,
                        input logic [N-1:0] num);
    @(negedge CLK);
    Start = 1'b1;
    Coc = c; Den = d; Res = r;
    q.push_back('{due: cyc + 1 + LAT, num: num, ovf: 1'b0});
  endtask

  task automatic idle();
    @(negedge CLK);
    Start = 1'b0;
    Coc = N'($urandom); Den = N'($urandom); Res = N'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 4 * LAT) begin
      idle();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (Done !== 1'b0 || Num !== '0 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s got Done=%b Num=%02h Ovf=%b want 0/00/0", name, Done, Num, Ovf);
    end
  endtask

  initial begin
    logic [N-1:0] a, b;
    int ai, bi;
    RSTa = 1'b0; Start = 1'b1;
    Coc = 8'd7; Den = 8'd3; Res = 8'd2;
    repeat (3) @(negedge CLK);
    #1 check_zero("reset_state");
    @(negedge CLK);
    Start = 1'b0;
    RSTa  = 1'b1;

    // Directed cases from the datasheet.
    op(8'd7, 8'd3, 8'd2);
    idle();
    op(-8'sd7, 8'd3, -8'sd2);
    op(-8'sd7, -8'sd3, 8'd2);
    op(8'h80, 8'd1, 8'd0);
    op(8'd127, 8'd2, 8'd0);
    op(8'h80, 8'h80, 8'd0);
    op(8'd0, 8'd99, 8'h85);
    op(8'd55, 8'd0, 8'd127);
    op(8'd127, 8'd1, 8'd1);
    drain();

    // Back-to-back launches, then a 1,0,1 pattern.
    for (int i = 1; i <= 5; i++) op(N'(i), 8'd10, 8'd1);
    op(8'd3, 8'd4, 8'd5);
    idle();
    op(-8'sd9, 8'd9, 8'd0);
    drain();

    // Reset while three ops are in flight; Start held high during reset is ignored.
    op(8'd11, 8'd11, 8'd0);
    op(8'd12, 8'd12, 8'd0);
    op(8'd13, 8'd2, 8'd0);
    idle();
    @(negedge CLK);
    #2;
    RSTa = 1'b0;
    Start = 1'b1;
    q.delete();
    last_num = '0;
    last_ovf = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) @(negedge CLK);
    #1 check_zero("reset_hold");
    @(negedge CLK);
    Start = 1'b0;
    RSTa  = 1'b1;
    repeat (LAT + 3) idle();
    op(8'd6, -8'sd7, 8'd1);
    drain();

    // Random traffic with random bubbles.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) op(N'($urandom), N'($urandom), N'($urandom));
      else idle();
    end
    drain();

    // Divider cross-check: truncating division then reconstruction must give the dividend.
    for (int i = 0; i < 60; i++) begin
      ai = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(0, 255)) - 128;
      if (bi == 0) bi = 3;
      if (ai == -128 && bi == -1) bi = 1;
      a = N'(ai);
      b = N'(bi);
      op_exp(N'(ai / bi), b, N'(ai % bi), a);
    end
    drain();

    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
